system_workers_cpu_2_cpu_mult_seq: RTL

SYSTEM_WORKERS_CPU_2_CPU_MULT_SEQ -- requirements
Module: system_workers_cpu_2_cpu_mult_seq

---
 rtl/system_workers_cpu_2_cpu_mult_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/system_workers_cpu_2_cpu_mult_seq.sv
// Sequential 32x32 unsigned multiplier front-end.
// Operands go to an external partial-product cell with a fixed pipeline
// latency. The cell returns lo*lo, lo*hi and hi*lo 16-bit products. The low
// word needs one pass through the cell. The high word takes a second pass that
// supplies hi*hi.
module system_workers_cpu_2_cpu_mult_seq #(
    parameter int MC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic        in_hi,
    output logic [31:0] mc_src1,
    output logic [31:0] mc_src2,
    output logic        mc_en,
    input  logic [31:0] mc_p1,
    input  logic [31:0] mc_p2,
    input  logic [31:0] mc_p3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ISSUE1   = 3'd1;
    localparam logic [2:0] WAIT1    = 3'd2;
    localparam logic [2:0] COLLECT1 = 3'd3;
    localparam logic [2:0] ISSUE2   = 3'd4;
    localparam logic [2:0] WAIT2    = 3'd5;
    localparam logic [2:0] COLLECT2 = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    // The WAIT states run for MC_LATENCY-1 cycles. The counter starts at
    // MC_LATENCY-2 and exits on zero. A latency of 1 skips WAIT entirely.
    localparam logic [1:0] WAIT_INIT = (MC_LATENCY > 1) ? 2'(MC_LATENCY - 2) : 2'd0;
    localparam bit         SKIP_WAIT = (MC_LATENCY <= 1);

    logic [2:0]  state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        hi_q;
    logic [63:0] acc_q;
    logic [1:0]  cnt_q;
    logic [31:0] mc_src1_q;
    logic [31:0] mc_src2_q;

    logic [32:0] mid_sum;
    logic [63:0] first_pass;
    logic [63:0] second_pass;

    // Combine the three partial products at full width. The 33-bit middle sum
    // keeps its carry.
    always_comb begin
        mid_sum     = {1'b0, mc_p2} + {1'b0, mc_p3};
        first_pass  = {32'h0, mc_p1} + ({31'h0, mid_sum} << 16);
        second_pass = acc_q + {mc_p1, 32'h0};
    end

    // Control FSM and datapath registers.
    // NOTE: every register in this block uses non-blocking assignments, so all
    // of them see pre-edge values. This holds even though one case arm both
    // loads and reads them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mc_src1_q <= '0;
            mc_src2_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= in_src1;
                        b_q       <= in_src2;
                        hi_q      <= in_hi;
                        mc_src1_q <= in_src1;
                        mc_src2_q <= in_src2;
                        state     <= ISSUE1;
                    end
                end
                ISSUE1: begin
                    cnt_q <= WAIT_INIT;
                    state <= SKIP_WAIT ? COLLECT1 : WAIT1;
                end
                WAIT1: begin
                    if (cnt_q == 2'd0) state <= COLLECT1;
                    else               cnt_q <= cnt_q - 2'd1;
                end
                COLLECT1: begin
                    acc_q <= first_pass;
                    if (hi_q) begin
                        mc_src1_q <= {16'h0, a_q[31:16]};
                        mc_src2_q <= {16'h0, b_q[31:16]};
                        state     <= ISSUE2;
                    end else begin
                        state <= DONE;
                    end
                end
                ISSUE2: begin
                    cnt_q <= WAIT_INIT;
                    state <= SKIP_WAIT ? COLLECT2 : WAIT2;
                end
                WAIT2: begin
                    if (cnt_q == 2'd0) state <= COLLECT2;
                    else               cnt_q <= cnt_q - 2'd1;
                end
                COLLECT2: begin
                    acc_q <= second_pass;
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held. This covers the first
    // reset cycle, when the registers still hold pre-reset contents.
    always_comb begin
        in_ready   = reset_n && (state == IDLE);
        out_valid  = reset_n && (state == DONE);
        mc_en      = reset_n && ((state == ISSUE1) || (state == ISSUE2));
        mc_src1    = reset_n ? mc_src1_q : 32'h0;
        mc_src2    = reset_n ? mc_src2_q : 32'h0;
        out_result = !reset_n ? 32'h0 : (hi_q ? acc_q[63:32] : acc_q[31:0]);
    end

endmodule
